// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and full/empty flags.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: none internally; the producer must never push into a full FIFO.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy tracking; flush empties the FIFO and wins over push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

  no_push_when_full: assert property (@(posedge clock) disable iff (reset) !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, response buffer, branch redirect.
// Latency: imem response registered into the buffer, shown on inst the following cycle.
// Backpressure: requests stop when outstanding + buffered reaches BUF_DEPTH; stall holds the head.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        brn_tkn,
  input  logic [31:0] brn_target,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_CNT = (CW+1)'(BUF_DEPTH);

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   rsp_pc;        // PC of the next response that will be kept
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_nxt;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          credit_ok;
  logic          req_fire;
  logic          redirect;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Request valid decodes only registered state, so it cannot drop while waiting for ready.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_CNT;
  assign imem_req_valid = (state == FETCH) && credit_ok;
  assign imem_req_addr  = {pc[31:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign redirect       = brn_tkn && (state != BOOT);

  assign push       = imem_rsp_valid && (drop == '0) && !redirect;
  assign pop        = !fifo_empty && !stall && !redirect;
  assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  // Next in-flight count and stale-response count after this cycle's handshakes.
  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !imem_rsp_valid)      outstanding_nxt = outstanding + 1'b1;
    else if (!req_fire && imem_rsp_valid) outstanding_nxt = outstanding - 1'b1;
    drop_nxt = drop;
    if (imem_rsp_valid && (drop != '0))   drop_nxt = drop - 1'b1;
  end

  // FSM with PC, credit and drop bookkeeping; a redirect discards every request still in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        pc     <= word_align(brn_target);
        rsp_pc <= word_align(brn_target);
        drop   <= outstanding_nxt;
        state  <= (outstanding_nxt != '0) ? FLUSH : FETCH;
      end else begin
        if (req_fire) pc     <= pc + 32'd4;
        if (push)     rsp_pc <= rsp_pc + 32'd4;
        drop <= drop_nxt;
        case (state)
          BOOT:    state <= FETCH;
          FLUSH:   if (drop_nxt == '0) state <= FETCH;
          default: state <= state;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (redirect),
    .head_dat (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // When empty, inst_pc shows where the next kept word will come from.
  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? NOP_INST : head.inst;
  assign inst_pc    = fifo_empty ? rsp_pc   : head.pc;

endmodule
